// File: rtl/obstacle_manager.sv
// Obstacle slot manager: spawns, scrolls and retires NUM_OBS obstacles on game_tick strobes,
// with a lowest-free-slot spawner, a minimum spawn gap and an optional speed ramp.
// Optional feature macro: OBSTACLE_MANAGER_SPEED_RAMP_EN (speed ramps up over time when defined;
// otherwise speed is fixed at SPEED_INIT).
module obstacle_manager #(
  parameter int unsigned NUM_OBS          = 4,
  parameter int unsigned CONV             = 2,
  parameter int unsigned GEN_LINE         = 120,
  parameter int unsigned NUM_TYPES        = 4,
  parameter int unsigned MIN_GAP          = 20,
  parameter int unsigned SPAWN_THRESH     = 4,
  parameter int unsigned SPEED_INIT       = 1,
  parameter int unsigned SPEED_MAX        = 4,
  parameter int unsigned SPEED_STEP_TICKS = 600,
  localparam int unsigned POS_W           = 10 - CONV
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     game_tick,
  input  logic                     game_start,
  input  logic                     game_over,
  input  logic [7:0]               rng,
  output logic [NUM_OBS*POS_W-1:0] obs_pos,
  output logic [NUM_OBS*3-1:0]     obs_type,
  output logic [NUM_OBS-1:0]       obs_active,
  output logic [3:0]               speed,
  output logic                     spawn_pulse
);

  localparam logic [7:0]       MinGap      = 8'(MIN_GAP);
  localparam logic [POS_W-1:0] GenLine     = POS_W'(GEN_LINE);
  localparam logic [2:0]       TypeMask    = 3'(NUM_TYPES - 1);
  localparam logic [4:0]       SpawnThresh = 5'(SPAWN_THRESH);
  localparam logic [3:0]       SpeedInit   = 4'(SPEED_INIT);

  typedef enum logic [1:0] {StIdle, StRun, StFrozen} state_e;

  state_e               state_q, state_d;
  logic [POS_W-1:0]     pos_q  [NUM_OBS];
  logic [POS_W-1:0]     pos_d  [NUM_OBS];
  logic [2:0]           type_q [NUM_OBS];
  logic [2:0]           type_d [NUM_OBS];
  logic [NUM_OBS-1:0]   active_q, active_d;
  logic [NUM_OBS-1:0]   spawn_sel;
  logic [7:0]           gap_q, gap_d;
  logic                 spawn_q, spawn_d;
  logic                 tick_run;
  logic                 spawn_ok;
  logic                 free_found;
  logic [POS_W-1:0]     spd;
  logic                 unused_rng;

  assign unused_rng = rng[4];

`ifdef OBSTACLE_MANAGER_SPEED_RAMP_EN
  localparam logic [3:0]  SpeedMax  = 4'(SPEED_MAX);
  localparam logic [15:0] StepTicks = 16'(SPEED_STEP_TICKS);

  logic [3:0]  speed_q, speed_d;
  logic [15:0] step_q, step_d, step_inc;

  assign speed    = speed_q;
  assign step_inc = step_q + 16'd1;
`else
  logic unused_ramp_cfg;

  assign speed           = SpeedInit;
  assign unused_ramp_cfg = ^{4'(SPEED_MAX), 16'(SPEED_STEP_TICKS)};
`endif

  assign spd      = POS_W'(speed);
  // A tick coinciding with start or over is dropped.
  assign tick_run = game_tick && !game_start && !game_over && (state_q == StRun);
  // Free-slot test uses occupancy before this tick's retirements.
  assign spawn_ok = (gap_q == MinGap) && ({1'b0, rng[3:0]} < SpawnThresh) && !(&active_q);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: start wins over everything, over only freezes a running game.
  always_comb begin
    state_d = state_q;
    if (game_start) begin
      state_d = StRun;
    end else if (game_over && (state_q == StRun)) begin
      state_d = StFrozen;
    end
  end

  // Lowest-index free slot as a one-hot select.
  always_comb begin
    spawn_sel  = '0;
    free_found = 1'b0;
    for (int i = 0; i < NUM_OBS; i++) begin
      spawn_sel[i] = !active_q[i] && !free_found;
      free_found   = free_found || !active_q[i];
    end
  end

  // Datapath next-state: clear on start, move/retire/spawn on a running tick.
  always_comb begin
    pos_d    = pos_q;
    type_d   = type_q;
    active_d = active_q;
    gap_d    = gap_q;
    spawn_d  = 1'b0;
`ifdef OBSTACLE_MANAGER_SPEED_RAMP_EN
    speed_d  = speed_q;
    step_d   = step_q;
`endif
    if (game_start) begin
      for (int i = 0; i < NUM_OBS; i++) begin
        pos_d[i]  = '0;
        type_d[i] = '0;
      end
      active_d = '0;
      gap_d    = MinGap;
`ifdef OBSTACLE_MANAGER_SPEED_RAMP_EN
      speed_d  = SpeedInit;
      step_d   = '0;
`endif
    end else if (tick_run) begin
      for (int i = 0; i < NUM_OBS; i++) begin
        if (active_q[i]) begin
          if (pos_q[i] >= spd) begin
            pos_d[i] = pos_q[i] - spd;
          end else begin
            pos_d[i]    = '0;
            type_d[i]   = '0;
            active_d[i] = 1'b0;
          end
        end
      end
      if (spawn_ok) begin
        for (int i = 0; i < NUM_OBS; i++) begin
          if (spawn_sel[i]) begin
            pos_d[i]    = GenLine;
            type_d[i]   = rng[7:5] & TypeMask;
            active_d[i] = 1'b1;
          end
        end
        // The spawn tick itself counts as the first tick of the new gap.
        gap_d   = 8'd1;
        spawn_d = 1'b1;
      end else if (gap_q != MinGap) begin
        gap_d = gap_q + 8'd1;
      end
`ifdef OBSTACLE_MANAGER_SPEED_RAMP_EN
      if (step_inc == StepTicks) begin
        step_d = '0;
        if (speed_q < SpeedMax) begin
          speed_d = speed_q + 4'd1;
        end
      end else begin
        step_d = step_inc;
      end
`endif
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_OBS; i++) begin
        pos_q[i]  <= '0;
        type_q[i] <= '0;
      end
      active_q <= '0;
      gap_q    <= '0;
      spawn_q  <= 1'b0;
    end else begin
      pos_q    <= pos_d;
      type_q   <= type_d;
      active_q <= active_d;
      gap_q    <= gap_d;
      spawn_q  <= spawn_d;
    end
  end

`ifdef OBSTACLE_MANAGER_SPEED_RAMP_EN
  // Speed ramp registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      speed_q <= SpeedInit;
      step_q  <= '0;
    end else begin
      speed_q <= speed_d;
      step_q  <= step_d;
    end
  end
`endif

  // Pack slot arrays onto the flat output buses.
  always_comb begin
    obs_pos  = '0;
    obs_type = '0;
    for (int i = 0; i < NUM_OBS; i++) begin
      obs_pos[i*POS_W +: POS_W] = pos_q[i];
      obs_type[i*3 +: 3]        = type_q[i];
    end
  end

  assign obs_active  = active_q;
  assign spawn_pulse = spawn_q;

endmodule
